pts_stream_serializer: RTL and testbench

//  Parametrised parallel-to-serial converter with valid/ready input and one-deep holding buffer.

---
 rtl/pts_pkg.sv | 15 +
 rtl/pts_shift_core.sv | 55 +++++
 rtl/pts_stream_serializer.sv | 122 ++++++++++++
 tb/tb_pts_stream_serializer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pts_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial stream serializer.
package pts_pkg;

  typedef enum logic {PTS_IDLE, PTS_SHIFT} pts_state_t;

  function automatic int beats(input int word_bits, input int lanes);
    return word_bits / lanes;
  endfunction

  // A single-beat word still needs a 1-bit counter.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pts_shift_core.sv
// Shift register and beat counter: load, shift toward the output end with fill, clear to idle level.
module pts_shift_core
  import pts_pkg::*;
#(
  parameter int   WORD_BITS = 8,
  parameter int   LANES     = 1,
  parameter bit   SHIFT_MSB = 1'b1,
  parameter logic IDLE_VAL  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 shift,
  input  logic [WORD_BITS-1:0] load_data,
  output logic [LANES-1:0]     beat,
  output logic                 last
);

  localparam int BEATS = beats(WORD_BITS, LANES);
  localparam int CNT_W = cnt_bits(BEATS);
  localparam logic [WORD_BITS-1:0] ALL_FILL = {WORD_BITS{IDLE_VAL}};
  localparam logic [WORD_BITS-1:0] FILL_LO  = ALL_FILL >> (WORD_BITS - LANES);
  localparam logic [WORD_BITS-1:0] FILL_HI  = ALL_FILL << (WORD_BITS - LANES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BEATS - 1);

  logic [WORD_BITS-1:0] sr;
  logic [WORD_BITS-1:0] sr_shifted;
  logic [CNT_W-1:0]     cnt;

  // Vacated positions at the far end are refilled with the idle level.
  always_comb begin
    sr_shifted = SHIFT_MSB ? ((sr << LANES) | FILL_LO) : ((sr >> LANES) | FILL_HI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= ALL_FILL;
      cnt <= '0;
    end else if (clear) begin
      sr  <= ALL_FILL;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (shift) begin
      sr  <= sr_shifted;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign beat = SHIFT_MSB ? sr[WORD_BITS-1 -: LANES] : sr[LANES-1:0];
  assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/pts_stream_serializer.sv
// Valid/ready parallel-to-serial converter with a one-deep holding buffer and
// back-to-back word streaming; LANES bits leave per shift_en tick.
module pts_stream_serializer
  import pts_pkg::*;
#(
  parameter int   WORD_BITS = 8,
  parameter int   LANES     = 1,
  parameter bit   SHIFT_MSB = 1'b1,
  parameter logic IDLE_VAL  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 shift_en,
  input  logic                 flush,
  output logic [LANES-1:0]     serial_out,
  output logic                 busy,
  output logic                 word_start,
  output logic                 word_done
);

  if (WORD_BITS % LANES != 0) begin : g_bad_cfg
    $error("pts_stream_serializer: WORD_BITS must be a multiple of LANES");
  end

  pts_state_t           state, state_n;
  logic                 hold_full;
  logic [WORD_BITS-1:0] hold_data;
  logic                 word_start_q;
  logic                 accept, consume, load, shift, clear;
  logic [LANES-1:0]     core_beat;
  logic                 core_last;

  assign accept = in_valid & ~hold_full & ~flush;

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    shift     = 1'b0;
    clear     = 1'b0;
    consume   = 1'b0;
    word_done = 1'b0;
    if (flush) begin
      state_n = PTS_IDLE;
      clear   = 1'b1;
    end else begin
      case (state)
        PTS_IDLE: begin
          if (hold_full) begin
            load    = 1'b1;
            consume = 1'b1;
            state_n = PTS_SHIFT;
          end
        end
        PTS_SHIFT: begin
          if (shift_en) begin
            if (core_last) begin
              word_done = 1'b1;
              // Reload straight from the buffer so the next word follows with no gap.
              if (hold_full) begin
                load    = 1'b1;
                consume = 1'b1;
              end else begin
                clear   = 1'b1;
                state_n = PTS_IDLE;
              end
            end else begin
              shift = 1'b1;
            end
          end
        end
        default: state_n = PTS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PTS_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      word_start_q <= 1'b0;
    end else begin
      word_start_q <= load;
      hold_full    <= flush ? 1'b0 : (accept | (hold_full & ~consume));
      if (accept) begin
        hold_data <= in_data;
      end
    end
  end

  pts_shift_core #(
    .WORD_BITS (WORD_BITS),
    .LANES     (LANES),
    .SHIFT_MSB (SHIFT_MSB),
    .IDLE_VAL  (IDLE_VAL)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .shift     (shift),
    .load_data (hold_data),
    .beat      (core_beat),
    .last      (core_last)
  );

  assign in_ready   = ~hold_full;
  assign busy       = (state == PTS_SHIFT);
  assign word_start = word_start_q;
  assign serial_out = busy ? core_beat : {LANES{IDLE_VAL}};

endmodule

// File: tb/tb_pts_stream_serializer.sv
// Directed bench: per-cycle vector table for the default MSB-first build plus
// hand-written sequences for LSB/2-lane, sparse ticks and async reset.
module tb_pts_stream_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0, in_ready, shift_en = 1'b0, flush = 1'b0;
  logic       serial_out, busy, word_start, word_done;

  logic [7:0] in_data2 = '0;
  logic       in_valid2 = 1'b0, in_ready2, shift_en2 = 1'b1, flush2 = 1'b0;
  logic [1:0] serial_out2;
  logic       busy2, word_start2, word_done2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pts_stream_serializer #(.WORD_BITS(8), .LANES(1), .SHIFT_MSB(1'b1), .IDLE_VAL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .shift_en(shift_en), .flush(flush), .serial_out(serial_out), .busy(busy),
    .word_start(word_start), .word_done(word_done)
  );

  pts_stream_serializer #(.WORD_BITS(8), .LANES(2), .SHIFT_MSB(1'b0), .IDLE_VAL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .shift_en(shift_en2), .flush(flush2), .serial_out(serial_out2), .busy(busy2),
    .word_start(word_start2), .word_done(word_done2)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       se;
    logic       fl;
    logic       ser;
    logic       st;
    logic       dn;
    logic       rdy;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic se, input logic fl,
                              input logic ser, input logic st, input logic dn, input logic rdy,
                              input logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.se = se; r.fl = fl;
    r.ser = ser; r.st = st; r.dn = dn; r.rdy = rdy; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic se, input logic fl);
    @(negedge clk);
    in_valid = v; in_data = d; shift_en = se; flush = fl;
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic ser, input logic st,
                         input logic dn, input logic rdy, input logic bsy);
    chk({tag, "_ser"},   idx, 8'(serial_out), 8'(ser));
    chk({tag, "_start"}, idx, 8'(word_start), 8'(st));
    chk({tag, "_done"},  idx, 8'(word_done),  8'(dn));
    chk({tag, "_ready"}, idx, 8'(in_ready),   8'(rdy));
    chk({tag, "_busy"},  idx, 8'(busy),       8'(bsy));
  endtask

  logic [7:0]  w_a5, w_81, w_42, w_5a;
  logic [15:0] w_b2b;
  logic [7:0]  exp2 [4];

  initial begin
    w_a5 = 8'hA5; w_81 = 8'h81; w_42 = 8'h42; w_5a = 8'h5A; w_b2b = 16'hF00F;
    exp2 = '{8'h0, 8'h1, 8'h3, 8'h2};

    // Single word 0xA5, shift_en held high.
    vecs.push_back(mk(1, 8'hA5, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 8'h00, 1, 0, w_a5[7-k], k == 0, k == 7, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 0));
    // Back-to-back 0xF0, 0x0F with the second word waiting in the buffer.
    vecs.push_back(mk(1, 8'hF0, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'h0F, 1, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(k == 0, 8'h0F, 1, 0, w_b2b[15-k], (k == 0) || (k == 8),
                        (k == 7) || (k == 15), (k == 0) || (k >= 8), 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 0));
    // Flush on the 4th beat of 0x3C while 0x55 is held.
    vecs.push_back(mk(1, 8'h3C, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h55, 1, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0, 0, 1));
    for (int k = 0; k < 11; k++)
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 0));

    #3;
    chk_all("reset", 0, 1, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].se, vecs[i].fl);
      chk_all("vec", i, vecs[i].ser, vecs[i].st, vecs[i].dn, vecs[i].rdy, vecs[i].bsy);
    end

    // LSB-first, two lanes, 0xB4.
    @(negedge clk);
    in_valid2 = 1'b1; in_data2 = 8'hB4; #1;
    chk("l2_ready", 0, 8'(in_ready2), 8'h1);
    @(negedge clk);
    in_valid2 = 1'b0; #1;
    chk("l2_busy", 0, 8'(busy2), 8'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("l2_ser",   k, 8'(serial_out2), exp2[k]);
      chk("l2_done",  k, 8'(word_done2),  8'(k == 3));
      chk("l2_start", k, 8'(word_start2), 8'(k == 0));
    end
    @(negedge clk); #1;
    chk("l2_idle_ser",  0, 8'(serial_out2), 8'h3);
    chk("l2_idle_busy", 0, 8'(busy2),       8'h0);

    // Sparse shift_en (every 3rd cycle) on 0x81, 0x42 queued, 0x99 offered at the reload.
    step(1, 8'h81, 0, 0);
    chk("sp_acc_ready", 0, 8'(in_ready), 8'h1);
    step(0, 8'h00, 0, 0);
    chk("sp_idle_busy", 0, 8'(busy), 8'h0);
    for (int k = 0; k < 30; k++) begin
      step((k == 5) || (k == 23) || (k == 24), (k == 5) ? 8'h42 : 8'h99, (k % 3) == 2, 0);
      chk("sp_ser",   k, 8'(serial_out), 8'((k < 24) ? w_81[7 - k/3] : w_42[7 - (k-24)/3]));
      chk("sp_done",  k, 8'(word_done),  8'(k == 23));
      chk("sp_start", k, 8'(word_start), 8'((k == 0) || (k == 24)));
      chk("sp_ready", k, 8'(in_ready),   8'((k <= 5) || (k == 24)));
    end

    // Asynchronous reset between edges while 0x42 is mid-word and 0x99 is held.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all("arst", 0, 1, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    step(1, 8'h5A, 1, 0);
    chk("post_ready", 0, 8'(in_ready), 8'h1);
    step(0, 8'h00, 1, 0);
    chk("post_busy", 0, 8'(busy), 8'h0);
    for (int k = 0; k < 8; k++) begin
      step(0, 8'h00, 1, 0);
      chk_all("post", k, w_5a[7-k], k == 0, k == 7, 1, 1);
    end
    step(0, 8'h00, 1, 0);
    chk_all("post_idle", 0, 1, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

endmodule
